resp_token_matcher: RTL and testbench
=====================================

// Module: resp_token_matcher
// PURPOSE
//   Parametrised UART response recogniser. Scans the received byte stream for up to NUM_PAT
//   fixed strings in parallel, e.g. "OK\r\n" and "ERROR\r\n". Reports which string completed.
//   Adds an inter-byte timeout and per-pattern sticky flags. Sits after the UART RX byte
//   deframer, in front of the command sequencer.
// PARAMETERS
//   NUM_PAT     2                       number of patterns matched in parallel (1..4)
//   MAX_LEN     8                       max bytes per pattern (1..15)
//   PATS        {"\n\rRORRE","\n\rKO"}  packed NUM_PAT*MAX_LEN*8 bits. Pattern p byte k sits at
//                                       bits [(p*MAX_LEN+k)*8 +: 8]. Byte 0 is the first char.
//   LENS        {4'd7,4'd4}             packed NUM_PAT*4 bits. Length of pattern p; 0 disables it.
//   TIMEOUT_CYC 50000                   idle cycles between bytes before partial matches are
//                                       abandoned; 0 disables
// PORTS
//   iCLK          in   1        system clock
//   RST_n         in   1        asynchronous, active-low reset
//   RECEIVE_END   in   1        one-cycle strobe: rxd holds a new byte
//   rxd           in   8        received byte, valid when RECEIVE_END=1
//   arm           in   1        0 = clear all sticky flags every cycle
//   match_pulse   out  1        one-cycle pulse: a pattern completed
//   match_id      out  2        index of the completed pattern, valid with match_pulse
//   match_sticky  out  NUM_PAT  per-pattern flag: set on completion, cleared by arm=0
//   busy          out  1        some pattern has a partial match in progress
//   timeout       out  1        one-cycle pulse: partial matches abandoned by the timeout
// BEHAVIOUR
// - Reset
//   - RST_n=0 asynchronously clears all outputs, all pattern indices and the timeout counter.
// - Per-pattern index idx[p] (0..LEN-1) on each RECEIVE_END cycle:
//   - rxd==PATS[p][idx] and idx==LEN-1: idx<=0, pattern p completes.
//   - rxd==PATS[p][idx] otherwise: idx<=idx+1.
//   - Mismatch: idx<=1 if rxd==PATS[p][0], else idx<=0. Simple restart, not full KMP.
//   - With no RECEIVE_END, idx holds.
// - Completion outputs
//   - Registered: match_pulse/match_id are high for exactly the cycle after the RECEIVE_END
//     that carried the last byte.
//   - Several patterns completing on one byte: match_id = lowest index; all their sticky bits set.
// - Sticky flags
//   - Set on the completion edge; set has priority over clear in that cycle.
//   - Otherwise arm=0 clears them, one cycle after arm is sampled low.
//   - arm does not gate matching or match_pulse.
// - busy
//   - Registered OR of (idx[p]!=0).
// - Timeout
//   - The counter resets on every RECEIVE_END and counts while busy=1.
//   - When it reaches TIMEOUT_CYC-1 with no RECEIVE_END: all idx<=0, timeout pulses for
//     1 cycle, counter clears.
//   - A RECEIVE_END in that same cycle wins: the byte is processed normally, with no timeout.
//   - TIMEOUT_CYC=0 removes the counter.
// - Widths and disabled patterns
//   - Unused match_id high bits are 0.
//   - A pattern with LEN=0 never advances or completes.
// TESTING
//   1. Send 'O','K',0x0D,0x0A -> one match_pulse, match_id=0, match_sticky=2'b01, busy back to 0.
//   2. Send 'O','O','K',0x0D,0x0A -> match on the final byte. Restart on the repeated first char.
//   3. Send "ERROR",0x0D,0x0A -> match_id=1, sticky=2'b10. "OK" sent mid-string causes no false match.
//   4. TIMEOUT_CYC=20, send 'O','K', idle 25 cycles, then 0x0D,0x0A -> timeout pulse at
//      idle cycle 20 (relative to the last RECEIVE_END), no match.
//   5. After test 1, drive arm=0 for 1 cycle -> sticky=0 next cycle. A completion in the same
//      cycle as arm=0 keeps its bit set.
//   6. Send 'O','K', pulse RST_n low, then 0x0D,0x0A -> no match, all outputs 0 during reset.

Source files
------------

// File: rtl/resp_token_matcher_if.sv
// Byte-stream input and match-report output bundle of the UART response recogniser.
// The slave side is the recogniser; the master side feeds bytes and consumes results.
interface resp_token_matcher_if #(
  parameter int NUM_PAT = 2
);
  logic               RECEIVE_END;
  logic [7:0]         rxd;
  logic               arm;
  logic               match_pulse;
  logic [1:0]         match_id;
  logic [NUM_PAT-1:0] match_sticky;
  logic               busy;
  logic               timeout;

  modport master (
    output RECEIVE_END, rxd, arm,
    input  match_pulse, match_id, match_sticky, busy, timeout
  );

  modport slave (
    input  RECEIVE_END, rxd, arm,
    output match_pulse, match_id, match_sticky, busy, timeout
  );
endinterface

// File: rtl/resp_token_matcher.sv
// Parallel fixed-string recogniser for a UART byte stream with sticky per-pattern flags
// and an inter-byte timeout that abandons partial matches.
module resp_token_matcher #(
  parameter int                             NUM_PAT     = 2,
  parameter int                             MAX_LEN     = 8,
  parameter logic [NUM_PAT*MAX_LEN*8-1:0]   PATS        = {8'h00, "\n\rRORRE", 32'h0, "\n\rKO"},
  parameter logic [NUM_PAT*4-1:0]           LENS        = {4'd7, 4'd4},
  parameter int                             TIMEOUT_CYC = 50000
) (
  input  logic                 iCLK,
  input  logic                 RST_n,
  resp_token_matcher_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [3:0]         idx_reg [NUM_PAT];
  logic [NUM_PAT-1:0] complete;
  logic [NUM_PAT-1:0] active_next;
  logic               tmo_fire;

  logic               match_pulse_reg;
  logic [1:0]         match_id_reg;
  logic [1:0]         match_id_next;
  logic [NUM_PAT-1:0] sticky_reg;
  logic               busy_reg;
  logic               timeout_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PAT; gi++) begin : g_pat
      localparam logic [3:0] LEN = LENS[gi*4 +: 4];

      logic [7:0] cur_byte;
      logic [7:0] first_byte;
      logic [3:0] idx_next;
      logic       complete_p;

      assign first_byte = PATS[gi*MAX_LEN*8 +: 8];

      always_comb begin
        cur_byte = first_byte;
        for (int k = 0; k < MAX_LEN; k++) begin
          if (idx_reg[gi] == 4'(k)) cur_byte = PATS[(gi*MAX_LEN+k)*8 +: 8];
        end
      end

      // Mismatch restarts from scratch, re-using the byte only as a fresh first char
      always_comb begin
        idx_next   = idx_reg[gi];
        complete_p = 1'b0;
        if (LEN == 4'd0) begin
          idx_next = 4'd0;
        end else if (bus.RECEIVE_END) begin
          if (bus.rxd == cur_byte) begin
            if (idx_reg[gi] == LEN - 4'd1) begin
              idx_next   = 4'd0;
              complete_p = 1'b1;
            end else begin
              idx_next = idx_reg[gi] + 4'd1;
            end
          end else begin
            idx_next = (bus.rxd == first_byte) ? 4'd1 : 4'd0;
          end
        end else if (tmo_fire) begin
          idx_next = 4'd0;
        end
      end

      assign complete[gi]    = complete_p;
      assign active_next[gi] = (idx_next != 4'd0);

      always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n) idx_reg[gi] <= 4'd0;
        else        idx_reg[gi] <= idx_next;
      end
    end

    if (TIMEOUT_CYC > 0) begin : g_tmo
      logic [CNT_W-1:0] cnt_reg;

      // A byte arriving on the expiry cycle takes precedence over the timeout
      assign tmo_fire = busy_reg && !bus.RECEIVE_END && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

      always_ff @(posedge iCLK or negedge RST_n) begin
        if (!RST_n)
          cnt_reg <= '0;
        else if (bus.RECEIVE_END || tmo_fire || !busy_reg)
          cnt_reg <= '0;
        else
          cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin : g_no_tmo
      assign tmo_fire = 1'b0;
    end
  endgenerate

  always_comb begin
    match_id_next = 2'd0;
    for (int p = NUM_PAT - 1; p >= 0; p--) begin
      if (complete[p]) match_id_next = 2'(p);
    end
  end

  always_ff @(posedge iCLK or negedge RST_n) begin
    if (!RST_n) begin
      match_pulse_reg <= 1'b0;
      match_id_reg    <= 2'd0;
      sticky_reg      <= '0;
      busy_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      match_pulse_reg <= |complete;
      match_id_reg    <= match_id_next;
      sticky_reg      <= complete | (bus.arm ? sticky_reg : '0);
      busy_reg        <= |active_next;
      timeout_reg     <= tmo_fire;
    end
  end

  assign bus.match_pulse  = match_pulse_reg;
  assign bus.match_id     = match_id_reg;
  assign bus.match_sticky = sticky_reg;
  assign bus.busy         = busy_reg;
  assign bus.timeout      = timeout_reg;

endmodule

// File: tb/tb_resp_token_matcher.sv
// Bench for resp_token_matcher: table vectors, hand sequences for timeout/reset corners,
// and random byte streams compared against a string-based reference model.
module tb_resp_token_matcher;

  localparam int TCYC = 20;

  logic iCLK;
  logic RST_n;

  resp_token_matcher_if #(.NUM_PAT(2)) bus ();

  resp_token_matcher #(
    .NUM_PAT    (2),
    .MAX_LEN    (8),
    .TIMEOUT_CYC(TCYC)
  ) dut (
    .iCLK (iCLK),
    .RST_n(RST_n),
    .bus  (bus.slave)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;

  // Reference model state: progress into each pattern string
  string pat [2] = '{"OK\r\n", "ERROR\r\n"};
  int    m_pos [2];
  int    m_idle;
  bit    m_pulse;
  int    m_id;
  bit [1:0] m_sticky;
  bit    m_busy;
  bit    m_tmo;

  typedef struct {
    bit       re;
    byte      rxd;
    bit       arm;
    bit       pulse;
    bit [1:0] id;
    bit [1:0] sticky;
    bit       busy;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos[0] = 0; m_pos[1] = 0;
    m_idle = 0; m_pulse = 0; m_id = 0; m_sticky = 0; m_busy = 0; m_tmo = 0;
  endtask

  task automatic model_step(input bit re, input byte b, input bit a);
    bit [1:0] comp;
    bit       fire;
    bit       in_progress;
    comp = 0;
    fire = 0;
    in_progress = (m_pos[0] != 0) || (m_pos[1] != 0);
    if (re) begin
      m_idle = 0;
      for (int p = 0; p < 2; p++) begin
        if (pat[p].len() > 0) begin
          if (b == pat[p][m_pos[p]]) begin
            if (m_pos[p] == pat[p].len() - 1) begin
              comp[p] = 1'b1;
              m_pos[p] = 0;
            end else begin
              m_pos[p]++;
            end
          end else begin
            m_pos[p] = (b == pat[p][0]) ? 1 : 0;
          end
        end
      end
    end else if (in_progress) begin
      m_idle++;
      if (m_idle == TCYC) begin
        fire = 1'b1;
        m_idle = 0;
        m_pos[0] = 0; m_pos[1] = 0;
      end
    end else begin
      m_idle = 0;
    end
    m_pulse  = |comp;
    m_id     = comp[0] ? 0 : (comp[1] ? 1 : 0);
    m_sticky = comp | (a ? m_sticky : 2'b00);
    m_busy   = (m_pos[0] != 0) || (m_pos[1] != 0);
    m_tmo    = fire;
  endtask

  task automatic check_model();
    chk("pulse", int'(bus.match_pulse), int'(m_pulse));
    if (m_pulse) chk("id", int'(bus.match_id), m_id);
    chk("sticky", int'(bus.match_sticky), int'(m_sticky));
    chk("busy", int'(bus.busy), int'(m_busy));
    chk("timeout", int'(bus.timeout), int'(m_tmo));
  endtask

  task automatic step(input bit re, input byte b, input bit a);
    bus.RECEIVE_END = re;
    bus.rxd         = b;
    bus.arm         = a;
    @(posedge iCLK);
    #1;
    model_step(re, b, a);
    check_model();
    bus.RECEIVE_END = 1'b0;
  endtask

  task automatic add(input bit re, input byte b, input bit a, input bit pl,
                     input bit [1:0] id, input bit [1:0] st, input bit bz);
    vec_t v;
    v.re = re; v.rxd = b; v.arm = a; v.pulse = pl; v.id = id; v.sticky = st; v.busy = bz;
    tbl.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pulse"},   int'(bus.match_pulse),  0);
    chk({tag, "_id"},      int'(bus.match_id),     0);
    chk({tag, "_sticky"},  int'(bus.match_sticky), 0);
    chk({tag, "_busy"},    int'(bus.busy),         0);
    chk({tag, "_timeout"}, int'(bus.timeout),      0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  tpos;
    int  r;
    int  g;
    bit  re;
    bit  a;
    byte b;
    byte alpha [8];

    alpha = '{8'h4F, 8'h4B, 8'h0D, 8'h0A, 8'h45, 8'h52, 8'h58, 8'h00};

    bus.RECEIVE_END = 1'b0;
    bus.rxd         = 8'h00;
    bus.arm         = 1'b1;
    RST_n           = 1'b0;
    model_reset();
    repeat (3) @(posedge iCLK);
    #1;
    check_all_zero("reset");
    @(negedge iCLK);
    RST_n = 1'b1;
    @(posedge iCLK);
    #1;

    // "OK\r\n", arm clear, "OOK\r\n", "ERROR\r\n", "ERROKOR\r\n", completion with arm=0
    add(1, 8'h4F, 1, 0, 0, 2'b00, 1);
    add(1, 8'h4B, 1, 0, 0, 2'b00, 1);
    add(1, 8'h0D, 1, 0, 0, 2'b00, 1);
    add(1, 8'h0A, 1, 1, 0, 2'b01, 0);
    add(0, 8'h00, 0, 0, 0, 2'b00, 0);
    add(1, 8'h4F, 1, 0, 0, 2'b00, 1);
    add(1, 8'h4F, 1, 0, 0, 2'b00, 1);
    add(1, 8'h4B, 1, 0, 0, 2'b00, 1);
    add(1, 8'h0D, 1, 0, 0, 2'b00, 1);
    add(1, 8'h0A, 1, 1, 0, 2'b01, 0);
    add(0, 8'h00, 0, 0, 0, 2'b00, 0);
    add(1, 8'h45, 1, 0, 0, 2'b00, 1);
    add(1, 8'h52, 1, 0, 0, 2'b00, 1);
    add(1, 8'h52, 1, 0, 0, 2'b00, 1);
    add(1, 8'h4F, 1, 0, 0, 2'b00, 1);
    add(1, 8'h52, 1, 0, 0, 2'b00, 1);
    add(1, 8'h0D, 1, 0, 0, 2'b00, 1);
    add(1, 8'h0A, 1, 1, 1, 2'b10, 0);
    add(1, 8'h45, 1, 0, 0, 2'b10, 1);
    add(1, 8'h52, 1, 0, 0, 2'b10, 1);
    add(1, 8'h52, 1, 0, 0, 2'b10, 1);
    add(1, 8'h4F, 1, 0, 0, 2'b10, 1);
    add(1, 8'h4B, 1, 0, 0, 2'b10, 1);
    add(1, 8'h4F, 1, 0, 0, 2'b10, 1);
    add(1, 8'h52, 1, 0, 0, 2'b10, 0);
    add(1, 8'h0D, 1, 0, 0, 2'b10, 0);
    add(1, 8'h0A, 1, 0, 0, 2'b10, 0);
    add(1, 8'h4F, 1, 0, 0, 2'b10, 1);
    add(1, 8'h4B, 1, 0, 0, 2'b10, 1);
    add(1, 8'h0D, 1, 0, 0, 2'b10, 1);
    add(1, 8'h0A, 0, 1, 0, 2'b01, 0);
    add(0, 8'h00, 1, 0, 0, 2'b01, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].re, tbl[i].rxd, tbl[i].arm);
      chk($sformatf("tbl%0d_pulse", i), int'(bus.match_pulse), int'(tbl[i].pulse));
      if (tbl[i].pulse) chk($sformatf("tbl%0d_id", i), int'(bus.match_id), int'(tbl[i].id));
      chk($sformatf("tbl%0d_sticky", i), int'(bus.match_sticky), int'(tbl[i].sticky));
      chk($sformatf("tbl%0d_busy", i), int'(bus.busy), int'(tbl[i].busy));
    end

    // Timeout abandons "OK" exactly TCYC idle cycles after the last byte
    step(1, 8'h4F, 1);
    step(1, 8'h4B, 1);
    tpos = 0;
    for (int i = 1; i <= 25; i++) begin
      step(0, 8'h00, 1);
      if (bus.timeout && tpos == 0) tpos = i;
    end
    chk("tmo_position", tpos, TCYC);
    step(1, 8'h0D, 1);
    step(1, 8'h0A, 1);
    chk("tmo_no_match", int'(bus.match_pulse), 0);

    // A byte on the expiry cycle wins over the timeout
    step(1, 8'h4F, 1);
    step(1, 8'h4B, 1);
    repeat (TCYC - 1) step(0, 8'h00, 1);
    step(1, 8'h0D, 1);
    chk("tmo_race_no_pulse", int'(bus.timeout), 0);
    chk("tmo_race_busy", int'(bus.busy), 1);
    step(1, 8'h0A, 1);
    chk("tmo_race_match", int'(bus.match_pulse), 1);

    // Reset in the middle of a partial match
    step(1, 8'h4F, 1);
    step(1, 8'h4B, 1);
    #3;
    RST_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    @(posedge iCLK);
    #1;
    check_all_zero("held_rst");
    @(negedge iCLK);
    RST_n = 1'b1;
    step(1, 8'h0D, 1);
    step(1, 8'h0A, 1);
    chk("post_rst_no_match", int'(bus.match_pulse), 0);

    // Random byte streams with occasional long idle gaps
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        g = int'($urandom_range(15, 30));
        repeat (g) step(0, 8'h00, 1);
      end else begin
        re = ($urandom_range(0, 99) < 60);
        b  = alpha[$urandom_range(0, 7)];
        a  = ($urandom_range(0, 99) >= 5);
        step(re, b, a);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
